bias_ram_writer: RTL

BIAS_RAM_WRITER -- requirements
Module: bias_ram_writer

---
 rtl/bias_ram_writer_if.sv | 33 +++
 rtl/bias_ram_writer.sv | 109 ++++++++++
 2 files changed

// File: rtl/bias_ram_writer_if.sv
// Control, input stream and RAM write port of the bias RAM writer.
// The slave modport is the writer itself; master is whoever drives it.
interface bias_ram_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IN_WIDTH   = 8
);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  start;
  logic [NW-1:0]         num_words;
  logic                  abort;
  logic [IN_WIDTH-1:0]   s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [AW-1:0]         wr_addr;
  logic                  wr_en;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, num_words, abort, s_data, s_valid,
    input  s_ready, wr_data, wr_addr, wr_en, busy, done, error
  );

  modport slave (
    input  start, num_words, abort, s_data, s_valid,
    output s_ready, wr_data, wr_addr, wr_en, busy, done, error
  );
endinterface

// File: rtl/bias_ram_writer.sv
// Packs IN_WIDTH stream beats little-endian into DATA_WIDTH words and writes
// num_words consecutive words into a RAM starting at address 0.
module bias_ram_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IN_WIDTH   = 8
) (
  input logic               clk,
  input logic               rst_n,
  bias_ram_writer_if.slave  bus
);
  localparam int BEATS = DATA_WIDTH / IN_WIDTH;
  localparam int NW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                state;
  logic [NW-1:0]         wcnt;
  logic [NW-1:0]         num_q;
  logic [BW-1:0]         bcnt;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  wr_en_q;
  logic                  last_beat;

  always_comb begin
    word_nxt = asm_q;
    word_nxt[bcnt*IN_WIDTH +: IN_WIDTH] = bus.s_data;
  end

  assign last_beat = (bcnt == BW'(BEATS - 1));

  // An abort arriving during the WRITE cycle must still cancel the strobe.
  assign bus.wr_en = wr_en_q & ~bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      num_q       <= '0;
      bcnt        <= '0;
      asm_q       <= '0;
      wr_en_q     <= 1'b0;
      bus.wr_data <= '0;
      bus.wr_addr <= '0;
      bus.s_ready <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.error   <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_words == '0 || bus.num_words > NW'(DEPTH)) begin
              bus.error <= 1'b1;
            end else begin
              state       <= LOAD;
              wcnt        <= '0;
              bcnt        <= '0;
              num_q       <= bus.num_words;
              bus.s_ready <= 1'b1;
              bus.busy    <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state       <= IDLE;
            bcnt        <= '0;
            bus.s_ready <= 1'b0;
            bus.busy    <= 1'b0;
          end else if (bus.s_valid) begin
            asm_q <= word_nxt;
            if (last_beat) begin
              state       <= WRITE;
              bcnt        <= '0;
              wr_en_q     <= 1'b1;
              bus.wr_data <= word_nxt;
              bus.wr_addr <= wcnt[AW-1:0];
              bus.s_ready <= 1'b0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (wcnt == num_q - NW'(1)) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            state       <= LOAD;
            wcnt        <= wcnt + 1'b1;
            bus.s_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
